// File: rtl/mux_4to1_rr_arbiter_pkg.sv
// Shared constants and types for the 4-source round-robin mux arbiter.
// Both the arbiter and the mux it steers reuse the source count and select width.
package mux_4to1_rr_arbiter_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SRC-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_4to1_rr_arbiter_rr_pick4.sv
// Rotating-priority search over four requests: first set bit at or after start, wrapping.
// Purely combinational; shared by the idle and release decisions.
module mux_4to1_rr_arbiter_rr_pick4
    import mux_4to1_rr_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan in reverse so the earliest position in rotated order wins.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = start + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant and 2-bit mux select.
// An owner keeps the grant for at most HOLD_MAX consecutive cycles.
module mux_4to1_rr_arbiter
    import mux_4to1_rr_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               valid
);

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_MAX - 1);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic [SEL_W-1:0]   pick_start;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;

    // Idle searches past the last winner; release searches past the current owner.
    assign pick_start = (state_q == StIdle) ? last_q + SEL_W'(1) : sel_q + SEL_W'(1);

    mux_4to1_rr_arbiter_rr_pick4 u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d    = StGrant;
                    grant_d    = onehot(pick_idx);
                    sel_d      = pick_idx;
                    valid_d    = 1'b1;
                    last_d     = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            StGrant: begin
                if (req[sel_q] && (hold_cnt_q < HoldLast)) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end else if (pick_found) begin
                    // Covers both a hand-off and a re-grant to a sole requester.
                    grant_d    = onehot(pick_idx);
                    sel_d      = pick_idx;
                    valid_d    = 1'b1;
                    last_d     = pick_idx;
                    hold_cnt_d = '0;
                end else begin
                    // sel is left alone so the mux input stays stable while idle.
                    state_d    = StIdle;
                    grant_d    = '0;
                    valid_d    = 1'b0;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= SEL_W'(NUM_SRC - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Bench for the round-robin mux arbiter: two instances (burst 4 and burst 1) share stimulus
// and are compared every cycle against an owner/run-length model.
module tb_mux_4to1_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] grant4, grant1;
    logic [1:0] sel4, sel1;
    logic       valid4, valid1;

    int n_checks = 0;
    int n_errors = 0;

    // Model per instance: owner index (-1 none), cycles owned so far, last winner, select.
    int hold_lim[2] = '{4, 1};
    int m_owner[2];
    int m_run[2];
    int m_last[2];
    int m_sel[2];

    mux_4to1_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant4),
        .sel   (sel4),
        .valid (valid4)
    );

    mux_4to1_rr_arbiter #(.HOLD_MAX(1), .CNT_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant1),
        .sel   (sel1),
        .valid (valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_search(input logic [3:0] r, input int s);
        for (int k = 0; k < 4; k++) begin
            if (r[(s + k) % 4]) return (s + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_edge(input int u, input logic rn, input logic [3:0] r);
        int w;
        if (!rn) begin
            m_owner[u] = -1; m_run[u] = 0; m_last[u] = 3; m_sel[u] = 0;
        end else if (m_owner[u] < 0) begin
            w = rr_search(r, (m_last[u] + 1) % 4);
            if (w >= 0) begin
                m_owner[u] = w; m_run[u] = 1; m_last[u] = w; m_sel[u] = w;
            end
        end else if (r[m_owner[u]] && m_run[u] < hold_lim[u]) begin
            m_run[u]++;
        end else begin
            w = rr_search(r, (m_owner[u] + 1) % 4);
            if (w >= 0) begin
                m_owner[u] = w; m_run[u] = 1; m_last[u] = w; m_sel[u] = w;
            end else begin
                m_owner[u] = -1; m_run[u] = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_unit(input int u, input logic [3:0] g, input logic [1:0] s,
                              input logic v);
        logic [3:0] eg;
        string      nm;
        nm = (u == 0) ? "h4" : "h1";
        eg = (m_owner[u] < 0) ? 4'b0000 : 4'(1 << m_owner[u]);
        chk({nm, ".grant"}, g, eg);
        chk({nm, ".sel"}, {2'b00, s}, 4'(m_sel[u]));
        chk({nm, ".valid"}, {3'b000, v}, {3'b000, (m_owner[u] >= 0)});
        chk({nm, ".valid_eq_or_grant"}, {3'b000, v}, {3'b000, |g});
    endtask

    // One rising edge with the currently driven inputs, then check 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge(0, rst_n, req);
        model_edge(1, rst_n, req);
        #1;
        check_unit(0, grant4, sel4, valid4);
        check_unit(1, grant1, sel1, valid1);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        for (int u = 0; u < 2; u++) begin
            m_owner[u] = -1; m_run[u] = 0; m_last[u] = 3; m_sel[u] = 0;
        end
        steps(2);
        chk("reset.grant", grant4, 4'b0000);
        chk("reset.valid", {3'b000, valid4}, 4'b0000);

        // First search starts at source 0; source 1 wins.
        rst_n = 1'b1;
        req   = 4'b0110;
        step();
        chk("first.grant", grant4, 4'b0010);
        chk("first.sel", {2'b00, sel4}, 4'd1);

        // Full load: fair rotation, four cycles each.
        rst_n = 1'b0; req = 4'b0000; step();
        rst_n = 1'b1; req = 4'b1111;
        steps(4);
        chk("rot.src0", grant4, 4'b0001);
        step();
        chk("rot.src1", grant4, 4'b0010);
        steps(15);
        chk("rot.wrap", grant4, 4'b0001);

        // Sole requester re-granted at expiry, then dropped.
        rst_n = 1'b0; req = 4'b0000; step();
        rst_n = 1'b1; req = 4'b0001;
        steps(10);
        chk("sole.grant", grant4, 4'b0001);
        req = 4'b0000;
        step();
        chk("drop.grant", grant4, 4'b0000);
        chk("drop.sel", {2'b00, sel4}, 4'd0);

        // Owner drops mid-burst: hand-off to source 3 with no bubble.
        req = 4'b0010;
        steps(3);
        req = 4'b1000;
        step();
        chk("handoff.grant", grant4, 4'b1000);
        chk("handoff.sel", {2'b00, sel4}, 4'd3);

        // Reset mid-burst on source 2, then immediate re-grant.
        req = 4'b0100;
        steps(3);
        rst_n = 1'b0;
        step();
        chk("midrst.grant", grant4, 4'b0000);
        rst_n = 1'b1;
        step();
        chk("postrst.grant", grant4, 4'b0100);

        // Burst of 1 alternates between sources 1 and 3.
        req = 4'b1010;
        steps(2);
        chk("h1.alt_a", {2'b00, sel1}, 4'd1);
        step();
        chk("h1.alt_b", {2'b00, sel1}, 4'd3);
        steps(4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 3) != 0) req = 4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_4to1_rr_arbiter.md
Name: mux_4to1_rr_arbiter

Overview:
- Round-robin arbiter that drives the 2-bit select of a 4-to-1 multiplexer.
- Sits directly upstream of the mux: four sources raise requests, the arbiter grants one at a time, and `sel` steers that source's data through the mux.
- A grant is held while the owner keeps requesting, up to a bounded burst length, so no source can starve the others.

Parameters:
- HOLD_MAX, 4: maximum consecutive cycles one grant is held. Legal range is 1 to 2**CNT_W.
- CNT_W, 3: width of the hold counter. It must be able to represent HOLD_MAX-1.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: synchronous, active-low reset. Sampled on the rising edge of clk.
- req, input, 4: request vector; req[i]=1 means source i wants the mux.
- grant, output, 4: registered one-hot grant; all zero when no grant is active.
- sel, output, 2: registered mux select, the binary index of the granted source. Connects straight to the mux `sel`.
- valid, output, 1: registered; 1 while a grant is active, so downstream may consume the mux output.

Behaviour:
- All outputs are registered; there are no combinational paths from req to outputs.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, grant=4'b0000, sel=2'b00, valid=0, hold_cnt=0.
  - Priority pointer last=2'd3, so the first search starts at source 0.
  - Reset wins over every other event, including mid-grant.
- Round-robin search: from start index s, pick the first i in order s, s+1, s+2, s+3 (mod 4) with req[i]=1.
- IDLE state:
  - If req != 0 at an edge, register the search winner with s=last+1.
  - On that edge: grant=onehot(winner), sel=winner, valid=1, last=winner, hold_cnt=0, and go to GRANT.
  - Latency is one clock edge from req sampled to grant visible.
  - If req == 0, stay in IDLE; outputs unchanged.
- GRANT state, evaluated at each edge:
  - Hold: if req[sel]=1 and hold_cnt < HOLD_MAX-1, then hold_cnt++ and the grant is unchanged.
  - Release: if req[sel]=0 or hold_cnt == HOLD_MAX-1.
    - Search with s=sel+1 across the current req. The current owner is considered last.
    - If a winner exists, switch to it on the same edge with no idle bubble: update grant, sel, last=winner, hold_cnt=0, and stay in GRANT.
    - If the winner equals the current owner (sole requester at expiry), re-grant it. grant and sel stay the same, hold_cnt=0, and valid stays 1.
    - If req == 0, go to IDLE: grant=0, valid=0, hold_cnt=0. sel keeps its last value so the mux input stays stable.
- Simultaneous owner drop and counter expiry count as one release; it is not evaluated twice.
- A grant is never issued to a source whose req bit was 0 at the deciding edge.
- Invariants:
  - grant is all-zero or one-hot.
  - valid == |grant.
  - When valid=1, grant == onehot(sel).
- HOLD_MAX=1: every granted cycle is an expiry, so grants rotate each cycle among the active requesters.
- hold_cnt never exceeds HOLD_MAX-1 and never wraps.

Decomposition:
- Shared include header (guarded) holds:
  - state encodings (IDLE=1'b0, GRANT=1'b1);
  - the 4-source count and the 2-bit select width constant, reused by the mux and this arbiter.
- One natural sub-module: rr_pick4.
  - Combinational: inputs req[3:0] and start[1:0]; outputs found and idx[1:0].
  - It implements the rotating priority search and is used for both the IDLE and release decisions.

Test Plan:
- Reset, then req=4'b0110 → after 1 edge: grant=4'b0010, sel=1, valid=1. Pointer start at 0, source 0 idle, so source 1 wins.
- HOLD_MAX=4, req=4'b1111 held steady → grants 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles, with no cycle where valid=0.
- HOLD_MAX=4, req=4'b0001 only:
  - grant=0001 continuously, valid never drops, hold_cnt returns to 0 every 4 cycles (re-grant to same source).
  - Dropping req to 0 → next edge: grant=0000, valid=0, sel stays 0.
- Source 1 granted; req goes 4'b0010 → 4'b1000 after 2 granted cycles → next edge: grant=1000, sel=3, hold_cnt=0, no bubble.
- Grant active on source 2 mid-burst; rst_n=0 for one edge → grant=0, sel=0, valid=0. With req=4'b0100 still high and rst_n=1, the next edge gives grant=0100.
- HOLD_MAX=1, req=4'b1010 steady → sel alternates 1, 3, 1, 3 every cycle, with valid=1 throughout.
